clint_timer: RTL



---
 rtl/clint_timer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/clint_timer.sv
// Core-local interruptor: 64-bit mtime/mtimecmp pair plus msip bit behind a
// single-cycle slave bus, driving the timer and software interrupt lines.
module clint_timer #(
  parameter int ADDR_WIDTH = 16,
  parameter int TICK_DIV   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bus_req,
  input  logic                  bus_we,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic [31:0]           bus_wdata,
  output logic                  bus_rdy,
  output logic [31:0]           bus_rdata,
  output logic                  bus_err,
  output logic                  irq_timer,
  output logic                  irq_software
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  localparam logic [ADDR_WIDTH-1:0] A_MSIP   = ADDR_WIDTH'(16'h0000);
  localparam logic [ADDR_WIDTH-1:0] A_CMP_LO = ADDR_WIDTH'(16'h4000);
  localparam logic [ADDR_WIDTH-1:0] A_CMP_HI = ADDR_WIDTH'(16'h4004);
  localparam logic [ADDR_WIDTH-1:0] A_MT_LO  = ADDR_WIDTH'(16'hBFF8);
  localparam logic [ADDR_WIDTH-1:0] A_MT_HI  = ADDR_WIDTH'(16'hBFFC);

  logic [PW-1:0] presc_r;
  logic [63:0]   mtime_r;
  logic [63:0]   mtimecmp_r;
  logic          msip_r;
  logic          rdy_r;
  logic          err_r;
  logic [31:0]   rdata_r;
  logic          irq_timer_r;

  logic          tick_s;
  logic          hit_s;
  logic          wr_s;
  logic          sel_msip_s;
  logic          sel_cmp_lo_s;
  logic          sel_cmp_hi_s;
  logic          sel_mt_lo_s;
  logic          sel_mt_hi_s;
  logic [31:0]   rd_val_s;

  assign tick_s = (presc_r == PRESC_MAX);

  // Address decode and read mux; every mapped address is word aligned, so a
  // misaligned offset simply misses the map.
  always_comb begin
    sel_msip_s   = 1'b0;
    sel_cmp_lo_s = 1'b0;
    sel_cmp_hi_s = 1'b0;
    sel_mt_lo_s  = 1'b0;
    sel_mt_hi_s  = 1'b0;
    rd_val_s     = 32'h0000_0000;
    case (bus_addr)
      A_MSIP: begin
        sel_msip_s = 1'b1;
        rd_val_s   = {31'h0000_0000, msip_r};
      end
      A_CMP_LO: begin
        sel_cmp_lo_s = 1'b1;
        rd_val_s     = mtimecmp_r[31:0];
      end
      A_CMP_HI: begin
        sel_cmp_hi_s = 1'b1;
        rd_val_s     = mtimecmp_r[63:32];
      end
      A_MT_LO: begin
        sel_mt_lo_s = 1'b1;
        rd_val_s    = mtime_r[31:0];
      end
      A_MT_HI: begin
        sel_mt_hi_s = 1'b1;
        rd_val_s    = mtime_r[63:32];
      end
      default: begin
        rd_val_s = 32'h0000_0000;
      end
    endcase
  end

  assign hit_s = sel_msip_s | sel_cmp_lo_s | sel_cmp_hi_s | sel_mt_lo_s | sel_mt_hi_s;
  assign wr_s  = bus_req & bus_we & hit_s;

  // Free-running prescaler; bus traffic never disturbs its phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= '0;
    end else if (tick_s) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PW'(1'b1);
    end
  end

  // mtime: a bus write to either half overrides (and swallows) a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_r <= 64'h0000_0000_0000_0000;
    end else if (wr_s && sel_mt_lo_s) begin
      mtime_r <= {mtime_r[63:32], bus_wdata};
    end else if (wr_s && sel_mt_hi_s) begin
      mtime_r <= {bus_wdata, mtime_r[31:0]};
    end else if (tick_s) begin
      mtime_r <= mtime_r + 64'd1;
    end
  end

  // Compare register and software interrupt bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtimecmp_r <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_r     <= 1'b0;
    end else begin
      if (wr_s && sel_cmp_lo_s) mtimecmp_r[31:0]  <= bus_wdata;
      if (wr_s && sel_cmp_hi_s) mtimecmp_r[63:32] <= bus_wdata;
      if (wr_s && sel_msip_s)   msip_r            <= bus_wdata[0];
    end
  end

  // Timer interrupt compares the current registers, so it trails them by a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_timer_r <= 1'b0;
    end else begin
      irq_timer_r <= (mtime_r >= mtimecmp_r);
    end
  end

  // Bus response, one cycle after the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_r   <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= 32'h0000_0000;
    end else begin
      rdy_r   <= bus_req;
      err_r   <= bus_req & ~hit_s;
      rdata_r <= (bus_req && !bus_we && hit_s) ? rd_val_s : 32'h0000_0000;
    end
  end

  assign bus_rdy      = rdy_r;
  assign bus_err      = err_r;
  assign bus_rdata    = rdata_r;
  assign irq_timer    = irq_timer_r;
  assign irq_software = msip_r;

endmodule
